// File: rtl/biriscv_csr_commit.sv
// CSR commit pipeline: carries CSR results from E1 through E2 to WB.
// Merges memory faults and interrupts at E2 and owns the exception flush.
module biriscv_csr_commit #(
    parameter int SUPPORT_MMU = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        e1_valid_i,
    input  logic [31:0] e1_pc_i,
    input  logic [31:0] e1_opcode_i,
    input  logic [31:0] csr_result_e1_value_i,
    input  logic        csr_result_e1_write_i,
    input  logic [31:0] csr_result_e1_wdata_i,
    input  logic [5:0]  csr_result_e1_exception_i,
    input  logic [5:0]  mem_exception_e2_i,
    input  logic [31:0] mem_addr_e2_i,
    input  logic        take_interrupt_i,
    input  logic        stall_i,
    output logic        csr_writeback_write_o,
    output logic [11:0] csr_writeback_waddr_o,
    output logic [31:0] csr_writeback_wdata_o,
    output logic [5:0]  csr_writeback_exception_o,
    output logic [31:0] csr_writeback_exception_pc_o,
    output logic [31:0] csr_writeback_exception_addr_o,
    output logic        wb_rd_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_rd_value_o,
    output logic        flush_o,
    output logic        interrupt_inhibit_o
);

    localparam logic [5:0] EXC_ILLEGAL   = 6'h12;
    localparam logic [5:0] EXC_INTERRUPT = 6'h20;
    localparam logic [5:0] EXC_FENCE     = 6'h34;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [11:0] csr_addr;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        write;
        logic [31:0] wdata;
        logic [5:0]  exc;
    } e2_t;

    typedef struct packed {
        logic        write;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] exc_pc;
        logic [31:0] exc_addr;
        logic        rd_valid;
        logic [4:0]  rd_idx;
        logic [31:0] rd_value;
    } wb_t;

    e2_t         e2_q;
    e2_t         e1_d;
    wb_t         wb_q;
    wb_t         wb_d;
    logic [5:0]  mem_exc;
    logic [31:0] mem_addr;
    logic [5:0]  e2_exc;
    logic [31:0] e2_tval;
    logic        commit_ok;
    logic        flush;
    logic        unused_opcode;

    assign unused_opcode = ^{e1_opcode_i[19:12], e1_opcode_i[6:0]};

    assign mem_exc  = (SUPPORT_MMU != 0) ? mem_exception_e2_i : 6'h0;
    assign mem_addr = (SUPPORT_MMU != 0) ? mem_addr_e2_i : 32'h0;

    always_comb begin
        e1_d = '0;
        if (e1_valid_i) begin
            e1_d.valid    = 1'b1;
            e1_d.pc       = e1_pc_i;
            e1_d.csr_addr = e1_opcode_i[31:20];
            e1_d.rd       = e1_opcode_i[11:7];
            e1_d.value    = csr_result_e1_value_i;
            e1_d.write    = csr_result_e1_write_i;
            e1_d.wdata    = csr_result_e1_wdata_i;
            e1_d.exc      = csr_result_e1_exception_i;
        end
    end

    // Priority: CSR-unit fault, then memory fault, then interrupt.
    always_comb begin
        e2_exc  = 6'h0;
        e2_tval = 32'h0;
        if (e2_q.valid) begin
            if (e2_q.exc != 6'h0) begin
                e2_exc  = e2_q.exc;
                e2_tval = (e2_q.exc == EXC_ILLEGAL) ? e2_q.value : 32'h0;
            end else if (mem_exc != 6'h0) begin
                e2_exc  = mem_exc;
                e2_tval = mem_addr;
            end else if (take_interrupt_i) begin
                e2_exc  = EXC_INTERRUPT;
            end
        end
    end

    assign commit_ok = (e2_exc == 6'h0) || (e2_exc == EXC_FENCE);

    always_comb begin
        wb_d = '0;
        if (e2_q.valid) begin
            wb_d.write    = e2_q.write & commit_ok;
            wb_d.waddr    = e2_q.csr_addr;
            wb_d.wdata    = e2_q.wdata;
            wb_d.exc      = e2_exc;
            wb_d.exc_pc   = (e2_exc != 6'h0) ? e2_q.pc : 32'h0;
            wb_d.exc_addr = e2_tval;
            wb_d.rd_valid = (e2_q.write | (e2_q.rd != 5'd0)) & commit_ok;
            wb_d.rd_idx   = e2_q.rd;
            wb_d.rd_value = e2_q.value;
        end
    end

    assign flush = (wb_q.exc != 6'h0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e2_q <= '0;
            wb_q <= '0;
        end else begin
            if (flush) begin
                e2_q <= '0;
            end else if (!stall_i) begin
                e2_q <= e1_d;
            end
            // Stall drains a bubble into WB so the CSR write fires once.
            if (flush || stall_i) begin
                wb_q <= '0;
            end else begin
                wb_q <= wb_d;
            end
        end
    end

    assign csr_writeback_write_o          = wb_q.write;
    assign csr_writeback_waddr_o          = wb_q.waddr;
    assign csr_writeback_wdata_o          = wb_q.wdata;
    assign csr_writeback_exception_o      = wb_q.exc;
    assign csr_writeback_exception_pc_o   = wb_q.exc_pc;
    assign csr_writeback_exception_addr_o = wb_q.exc_addr;
    assign wb_rd_valid_o                  = wb_q.rd_valid;
    assign wb_rd_idx_o                    = wb_q.rd_idx;
    assign wb_rd_value_o                  = wb_q.rd_value;
    assign flush_o                        = flush;
    assign interrupt_inhibit_o = (e2_q.valid & e2_q.write) | (e2_exc != 6'h0) | flush;

endmodule

// File: doc/biriscv_csr_commit.md
Name: biriscv_csr_commit

Overview:
Commit pipeline for CSR-unit results. It takes the E1 CSR result, write data and early exception, and carries them through the E2 and WB stages. At E2 it merges memory-stage faults and pending interrupts. At WB it drives the CSR register-file writeback/exception port and the integer rd writeback. It sits between the CSR execute unit and the CSR register file, and owns pipeline flush on exceptions.

Parameters:
SUPPORT_MMU, 1, when 0, mem_exception_e2_i and mem_addr_e2_i are ignored (treated as 0).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
e1_valid_i  in  1  E1 holds a valid instruction
e1_pc_i  in  32  E1 instruction PC
e1_opcode_i  in  32  E1 opcode; bits [31:20] give the CSR address, bits [11:7] give rd
csr_result_e1_value_i  in  32  CSR read value, or faulting opcode (tval)
csr_result_e1_write_i  in  1  CSR write requested
csr_result_e1_wdata_i  in  32  CSR write data
csr_result_e1_exception_i  in  6  early exception code
mem_exception_e2_i  in  6  memory-stage fault for the E2 instruction
mem_addr_e2_i  in  32  faulting data address
take_interrupt_i  in  1  interrupt request from the CSR unit
stall_i  in  1  pipeline stall
csr_writeback_write_o  out  1  CSR write strobe
csr_writeback_waddr_o  out  12  CSR address
csr_writeback_wdata_o  out  32  CSR write data
csr_writeback_exception_o  out  6  committed exception code
csr_writeback_exception_pc_o  out  32  PC of the excepting instruction
csr_writeback_exception_addr_o  out  32  tval
wb_rd_valid_o  out  1  integer rd write enable
wb_rd_idx_o  out  5  rd index
wb_rd_value_o  out  32  rd value (old CSR value)
flush_o  out  1  squash all younger stages
interrupt_inhibit_o  out  1  to the CSR unit's interrupt_inhibit_i

Behaviour:
- Reset: all E2/WB state is cleared to a bubble. Every output is 0 while rst_i is high and on the first cycle after it.
- Stages: E1 inputs are captured into E2 at the clock edge; E2 is captured into WB at the next edge. WB registers drive the outputs directly. Latency is 2 cycles from E1 sample to outputs.
- Stall: when stall_i=1, E2 holds its contents and WB loads a bubble (all strobes 0). Each instruction's CSR write therefore fires exactly once.
- E2 exception merge, in priority order:
  - csr_result exception nonzero → keep it.
  - else mem_exception_e2_i nonzero → use it; tval = mem_addr_e2_i.
  - else take_interrupt_i=1 and E2 valid → 6'h20 (INTERRUPT); tval = 0.
  - else 0.
- tval selection for a CSR-unit exception:
  - illegal instruction (6'h12) → csr_result value (the opcode).
  - otherwise → 0.
- Any nonzero exception at E2 clears the CSR write and rd write in WB, except FENCE (6'h34), which keeps its CSR write (satp update).
- rd write: wb_rd_valid_o=1 only when a committed instruction carries csr_result write or rd≠0, and has no exception other than FENCE. wb_rd_value_o is the CSR read value.
- csr_writeback_exception_pc_o = the instruction PC when the exception is nonzero, else 0.
- Flush: flush_o = (csr_writeback_exception_o≠0), combinational from WB. In a flush cycle, E2 and the incoming E1 are discarded, so next E2 and next WB are bubbles. Flush overrides stall.
- Interrupt inhibit: interrupt_inhibit_o = E2 valid with a CSR write, or E2 exception≠0, or WB exception≠0. This prevents an interrupt racing an in-flight CSR update.
- A bubble (e1_valid_i=0) propagates with all strobes and codes zero.
- Reset asserted mid-operation: the next edge clears everything; no partial write is emitted.

Test Plan:
- CSRRW mscratch (0x340), wdata 0x1234, read 0xAA, rd=5, no stall → after 2 cycles: write=1, waddr=0x340, wdata=0x1234, rd_valid=1, idx=5, value=0xAA, exception=0, for one cycle.
- Same instruction with stall_i held 3 cycles at E2 → write strobe appears exactly once, 1 cycle after stall release.
- E1 exception 6'h12, value 0xDEADBEEF, pc 0x80000010 → exception=0x12, pc=0x80000010, addr=0xDEADBEEF, write=0, flush_o=1; the following E1 instruction is never committed.
- take_interrupt_i=1 while a valid non-faulting instruction (pc 0x100) sits in E2 → exception=0x20, pc=0x100, write=0, rd_valid=0.
- Simultaneous mem_exception 6'h15 (addr 0x2000) and take_interrupt_i → exception=0x15, addr=0x2000 (mem fault wins).
- Satp write carrying FENCE 6'h34 → write=1, exception=0x34, flush_o=1. Separately, rst_i mid-pipeline → all outputs 0 on the next cycle.
